// File: rtl/ctech_lib_latch_wr_seq_if.sv
// Write-request handshake bundle for the latch write sequencer.
// The master presents a request and the sequencer answers with wr_rdy.
interface ctech_lib_latch_wr_seq_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             wr_vld;
    logic             wr_rdy;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_vld, output wr_addr, output wr_data, input wr_rdy);
    modport slave  (input wr_vld, input wr_addr, input wr_data, output wr_rdy);
endinterface

// File: rtl/ctech_lib_latch_wr_seq.sv
// Write sequencer for a bank of phase latches: stages data one cycle ahead of
// a one-hot, single-cycle latch-open enable and holds it one cycle after.
module ctech_lib_latch_wr_seq #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_b,
    ctech_lib_latch_wr_seq_if.slave wr,
    output logic [WIDTH-1:0]       lat_d,
    output logic [DEPTH-1:0]       lat_en,
    output logic                   busy,
    output logic                   err_addr,
    output logic [7:0]             wr_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_lat_d;
    logic [DEPTH-1:0] r_lat_en;
    logic             r_err;
    logic [7:0]       r_cnt;

    logic w_rdy;
    logic w_xfer;
    logic w_addr_ok;
    logic w_take;

    function automatic logic [DEPTH-1:0] f_onehot(input logic [AW-1:0] a);
        return {{(DEPTH-1){1'b0}}, 1'b1} << a;
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign w_rdy     = (r_state == IDLE) || (r_state == HOLD);
    assign w_xfer    = wr.wr_vld && w_rdy;
    assign w_addr_ok = (32'(wr.wr_addr) < 32'(DEPTH));
    assign w_take    = w_xfer && w_addr_ok;

    // Request capture: data goes straight onto the latch bus, the address waits for OPEN.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= IDLE;
            r_lat_d  <= '0;
            r_lat_en <= '0;
            r_err    <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            r_err <= w_xfer && !w_addr_ok;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_lat_d <= wr.wr_data;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_lat_en <= f_onehot(r_addr);
                    r_state  <= OPEN;
                end
                OPEN: begin
                    r_lat_en <= '0;
                    r_cnt    <= f_sat_inc(r_cnt);
                    r_state  <= HOLD;
                end
                HOLD: begin
                    if (w_take) begin
                        r_lat_d <= wr.wr_data;
                        r_state <= SETUP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Captured target entry; only meaningful while a write is in flight.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_addr <= wr.wr_addr;
        end
    end

    assign wr.wr_rdy = w_rdy;
    assign lat_d     = r_lat_d;
    assign lat_en    = r_lat_en;
    assign busy      = (r_state != IDLE);
    assign err_addr  = r_err;
    assign wr_cnt    = r_cnt;
endmodule

// File: tb/tb_ctech_lib_latch_wr_seq.sv
// Bench for the latch write sequencer: fixed vector tables, directed corner
// sequences and a randomized run against a cycle-timeline reference model.
module tb_ctech_lib_latch_wr_seq;
    logic clk;
    logic rst_b;

    ctech_lib_latch_wr_seq_if #(.DEPTH(8), .WIDTH(16)) bus8 ();
    ctech_lib_latch_wr_seq_if #(.DEPTH(6), .WIDTH(16)) bus6 ();

    logic [15:0] lat_d8, lat_d6;
    logic [7:0]  lat_en8;
    logic [5:0]  lat_en6;
    logic        busy8, busy6, err8, err6;
    logic [7:0]  cnt8, cnt6;

    ctech_lib_latch_wr_seq #(.DEPTH(8), .WIDTH(16)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .wr(bus8.slave),
        .lat_d(lat_d8), .lat_en(lat_en8), .busy(busy8), .err_addr(err8), .wr_cnt(cnt8)
    );

    ctech_lib_latch_wr_seq #(.DEPTH(6), .WIDTH(16)) u_dut6 (
        .clk(clk), .rst_b(rst_b), .wr(bus6.slave),
        .lat_d(lat_d6), .lat_en(lat_en6), .busy(busy6), .err_addr(err6), .wr_cnt(cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: age = edges since the last accepted good write.
    // age 1 = data staged, age 2 = latch open, age 3 = hold, >=4 idle.
    int          m_depth[2] = '{8, 6};
    int          m_age[2];
    int          m_addr[2];
    logic [15:0] m_d[2];
    int          m_cnt[2];
    bit          m_err[2];
    logic [7:0]  m_prev_en[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_age[k] = 99; m_addr[k] = 0; m_d[k] = 16'h0;
            m_cnt[k] = 0; m_err[k] = 1'b0; m_prev_en[k] = 8'h0;
        end
    endtask

    task automatic check_dut(input int k);
        logic [7:0]  a_en, e_en, one;
        logic [15:0] a_d;
        logic        a_rdy, a_busy, a_err;
        logic [7:0]  a_cnt;
        string       p;
        one = 8'd1;
        if (k == 0) begin
            a_en = lat_en8; a_d = lat_d8; a_rdy = bus8.wr_rdy; a_busy = busy8; a_err = err8; a_cnt = cnt8;
        end else begin
            a_en = {2'b00, lat_en6}; a_d = lat_d6; a_rdy = bus6.wr_rdy; a_busy = busy6; a_err = err6; a_cnt = cnt6;
        end
        p = $sformatf("d%0d", m_depth[k]);
        e_en = (m_age[k] == 2) ? (one << m_addr[k]) : 8'h0;
        chk({p, "_lat_en"}, 32'(a_en), 32'(e_en));
        chk({p, "_lat_d"}, 32'(a_d), 32'(m_d[k]));
        chk({p, "_wr_rdy"}, 32'(a_rdy), 32'(!(m_age[k] == 1 || m_age[k] == 2)));
        chk({p, "_busy"}, 32'(a_busy), 32'(m_age[k] >= 1 && m_age[k] <= 3));
        chk({p, "_err_addr"}, 32'(a_err), 32'(m_err[k]));
        chk({p, "_wr_cnt"}, 32'(a_cnt), 32'(m_cnt[k]));
        chk({p, "_onehot"}, 32'($countones(a_en) <= 1), 32'd1);
        chk({p, "_en_adjacent"}, 32'((a_en != 8'h0) && (m_prev_en[k] != 8'h0)), 32'd0);
        m_prev_en[k] = a_en;
    endtask

    task automatic model_edge(input int k);
        bit          v, rdy, xfer;
        int          a;
        logic [15:0] d;
        if (k == 0) begin v = bus8.wr_vld; a = int'(bus8.wr_addr); d = bus8.wr_data; end
        else        begin v = bus6.wr_vld; a = int'(bus6.wr_addr); d = bus6.wr_data; end
        rdy  = !(m_age[k] == 1 || m_age[k] == 2);
        xfer = v && rdy;
        if (m_age[k] == 2) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        m_err[k] = xfer && (a >= m_depth[k]);
        if (xfer && a < m_depth[k]) begin
            m_age[k] = 1; m_d[k] = d; m_addr[k] = a;
        end else if (m_age[k] < 99) begin
            m_age[k]++;
        end
    endtask

    task automatic cyc_chk();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic cyc_edge();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        bus8.wr_vld = 1'b0; bus8.wr_addr = '0; bus8.wr_data = '0;
        bus6.wr_vld = 1'b0; bus6.wr_addr = '0; bus6.wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lat_en", 32'(lat_en8), 32'h0);
        chk("rst_lat_d", 32'(lat_d8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_wr_rdy", 32'(bus8.wr_rdy), 32'h1);
        chk("rst_err", 32'(err8), 32'h0);
        chk("rst_cnt", 32'(cnt8), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        cyc_edge();
    endtask

    typedef struct {
        bit          vld;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [7:0]  en;
        logic [15:0] d;
        bit          rdy;
        bit          busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tq[$];

    function automatic vec_t mkv(bit v, logic [2:0] a, logic [15:0] dt, logic [7:0] en,
                                 logic [15:0] d, bit rdy, bit bsy, logic [7:0] c);
        vec_t r;
        r.vld = v; r.addr = a; r.data = dt; r.en = en; r.d = d; r.rdy = rdy; r.busy = bsy; r.cnt = c;
        return r;
    endfunction

    task automatic apply_tbl(input string nm);
        foreach (tq[i]) begin
            bus8.wr_vld = tq[i].vld; bus8.wr_addr = tq[i].addr; bus8.wr_data = tq[i].data;
            cyc_chk();
            chk($sformatf("%s[%0d]_lat_en", nm, i), 32'(lat_en8), 32'(tq[i].en));
            chk($sformatf("%s[%0d]_lat_d", nm, i), 32'(lat_d8), 32'(tq[i].d));
            chk($sformatf("%s[%0d]_wr_rdy", nm, i), 32'(bus8.wr_rdy), 32'(tq[i].rdy));
            chk($sformatf("%s[%0d]_busy", nm, i), 32'(busy8), 32'(tq[i].busy));
            chk($sformatf("%s[%0d]_wr_cnt", nm, i), 32'(cnt8), 32'(tq[i].cnt));
            cyc_edge();
        end
        tq.delete();
        idle_inputs();
    endtask

    initial begin
        rst_b = 1'b0;
        idle_inputs();
        do_reset();

        // Single write to entry 5.
        tq.push_back(mkv(1, 3'd5, 16'h1234, 8'h00, 16'h0000, 1, 0, 8'd0));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h1234, 0, 1, 8'd0));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h20, 16'h1234, 0, 1, 8'd0));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h1234, 1, 1, 8'd1));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h1234, 1, 0, 8'd1));
        apply_tbl("single");

        // Back-to-back writes with wr_vld held.
        do_reset();
        tq.push_back(mkv(1, 3'd0, 16'h1111, 8'h00, 16'h0000, 1, 0, 8'd0));
        tq.push_back(mkv(1, 3'd7, 16'h7777, 8'h00, 16'h1111, 0, 1, 8'd0));
        tq.push_back(mkv(1, 3'd7, 16'h7777, 8'h01, 16'h1111, 0, 1, 8'd0));
        tq.push_back(mkv(1, 3'd7, 16'h7777, 8'h00, 16'h1111, 1, 1, 8'd1));
        tq.push_back(mkv(1, 3'd2, 16'h2222, 8'h00, 16'h7777, 0, 1, 8'd1));
        tq.push_back(mkv(1, 3'd2, 16'h2222, 8'h80, 16'h7777, 0, 1, 8'd1));
        tq.push_back(mkv(1, 3'd2, 16'h2222, 8'h00, 16'h7777, 1, 1, 8'd2));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h2222, 0, 1, 8'd2));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h04, 16'h2222, 0, 1, 8'd2));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h2222, 1, 1, 8'd3));
        tq.push_back(mkv(0, 3'd0, 16'h0000, 8'h00, 16'h2222, 1, 0, 8'd3));
        apply_tbl("b2b");

        // Reset asserted while the latch is open.
        do_reset();
        bus8.wr_vld = 1'b1; bus8.wr_addr = 3'd3; bus8.wr_data = 16'hA5A5;
        cyc_chk(); cyc_edge();
        bus8.wr_vld = 1'b0;
        cyc_chk(); cyc_edge();
        chk("rmid_open_lat_en", 32'(lat_en8), 32'h08);
        #2 rst_b = 1'b0;
        #1;
        chk("rmid_lat_en", 32'(lat_en8), 32'h0);
        chk("rmid_lat_d", 32'(lat_d8), 32'h0);
        chk("rmid_busy", 32'(busy8), 32'h0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        cyc_edge();
        repeat (3) begin cyc_chk(); cyc_edge(); end
        chk("rmid_wr_cnt", 32'(cnt8), 32'h0);
        chk("rmid_wr_rdy", 32'(bus8.wr_rdy), 32'h1);

        // Out-of-range addresses from IDLE on the 6-entry instance.
        do_reset();
        bus6.wr_vld = 1'b1; bus6.wr_addr = 3'd6;
        cyc_chk(); cyc_edge();
        bus6.wr_vld = 1'b0;
        cyc_chk();
        chk("bad6_err", 32'(err6), 32'h1);
        chk("bad6_lat_en", 32'(lat_en6), 32'h0);
        chk("bad6_busy", 32'(busy6), 32'h0);
        cyc_edge();
        bus6.wr_vld = 1'b1; bus6.wr_addr = 3'd7;
        cyc_chk(); cyc_edge();
        bus6.wr_vld = 1'b0;
        cyc_chk();
        chk("bad7_err", 32'(err6), 32'h1);
        chk("bad7_cnt", 32'(cnt6), 32'h0);
        cyc_edge();
        bus6.wr_vld = 1'b1; bus6.wr_addr = 3'd4; bus6.wr_data = 16'hBEEF;
        cyc_chk(); cyc_edge();
        bus6.wr_vld = 1'b0;
        cyc_chk();
        chk("good4_err", 32'(err6), 32'h0);
        chk("good4_lat_d", 32'(lat_d6), 32'hBEEF);
        cyc_edge();
        cyc_chk();
        chk("good4_lat_en", 32'(lat_en6), 32'h10);
        cyc_edge();
        cyc_chk();
        chk("good4_cnt", 32'(cnt6), 32'h1);
        cyc_edge();

        // Out-of-range request arriving during HOLD.
        bus6.wr_vld = 1'b1; bus6.wr_addr = 3'd1; bus6.wr_data = 16'h0101;
        cyc_chk(); cyc_edge();
        bus6.wr_vld = 1'b0;
        cyc_chk(); cyc_edge();
        cyc_chk(); cyc_edge();
        bus6.wr_vld = 1'b1; bus6.wr_addr = 3'd6; bus6.wr_data = 16'hDEAD;
        cyc_chk();
        chk("hold_rdy", 32'(bus6.wr_rdy), 32'h1);
        chk("hold_busy", 32'(busy6), 32'h1);
        cyc_edge();
        bus6.wr_vld = 1'b0;
        cyc_chk();
        chk("hold_bad_err", 32'(err6), 32'h1);
        chk("hold_bad_busy", 32'(busy6), 32'h0);
        chk("hold_bad_lat_d", 32'(lat_d6), 32'h0101);
        chk("hold_bad_cnt", 32'(cnt6), 32'h2);
        cyc_edge();

        // Randomized stalls on both instances against the model.
        for (int i = 0; i < 2000; i++) begin
            bus8.wr_vld  = 1'($urandom_range(0, 1));
            bus8.wr_addr = 3'($urandom_range(0, 7));
            bus8.wr_data = 16'($urandom);
            bus6.wr_vld  = 1'($urandom_range(0, 1));
            bus6.wr_addr = 3'($urandom_range(0, 7));
            bus6.wr_data = 16'($urandom);
            cyc_chk(); cyc_edge();
        end
        idle_inputs();

        // Count saturation with continuous back-to-back writes.
        do_reset();
        bus8.wr_vld = 1'b1;
        for (int i = 0; i < 262 * 3; i++) begin
            bus8.wr_addr = 3'($urandom_range(0, 7));
            bus8.wr_data = 16'($urandom);
            cyc_chk(); cyc_edge();
        end
        chk("sat_cnt", 32'(cnt8), 32'd255);
        repeat (9) begin cyc_chk(); cyc_edge(); end
        chk("sat_cnt_hold", 32'(cnt8), 32'd255);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctech_lib_latch_wr_seq.md
# ctech_lib_latch_wr_seq

Write sequencer that sits directly upstream of a bank of `ctech_lib_latch_p`-style phase latches. It accepts write requests over a valid/ready handshake and stages the write data on a dedicated data bus. It then produces a one-hot, one-cycle latch-open enable per entry, bracketed by a setup cycle and a hold cycle, so downstream latches never see data changing while open. A per-entry clock gate (outside this block) turns each enable into the latch `clkb`.

## Interface
- `DEPTH`, 8 — number of latch entries (2..64, need not be a power of two).
- `WIDTH`, 16 — data width in bits (1..128).
- `AW`, derived, `$clog2(DEPTH)` (minimum 1) — address width.

Ports:
- `clk`  in  1  — the block's only clock; all state is rising-edge.
- `rst_b`  in  1  — asynchronous, active-low reset.
- `wr_vld`  in  1  — write request valid.
- `wr_rdy`  out  1  — block can accept a request this cycle.
- `wr_addr`  in  AW  — target entry.
- `wr_data`  in  WIDTH  — write data.
- `lat_d`  out  WIDTH  — data bus to all latch `d` inputs (registered).
- `lat_en`  out  DEPTH  — one-hot latch-open enable (registered); bit i opens entry i.
- `busy`  out  1  — a write is in flight (state ≠ IDLE).
- `err_addr`  out  1  — one-cycle pulse when an accepted request has `wr_addr >= DEPTH`.
- `wr_cnt`  out  8  — saturating count of completed (non-error) writes.

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- Handshake:
  - A transfer occurs when `wr_vld && wr_rdy` at a rising edge.
  - `wr_rdy = (state == IDLE) || (state == HOLD)`, decoded combinationally from the state register.
  - `wr_vld` is not required to be held; nothing is captured without `wr_rdy`.
- IDLE:
  - On a transfer with a valid address, capture `wr_addr` and `wr_data` and go to SETUP.
  - On a transfer with `wr_addr >= DEPTH`, capture nothing and stay in IDLE. `err_addr` = 1 next cycle; `lat_d`, `lat_en` and `wr_cnt` are unchanged.
- SETUP: `lat_d` = captured data, `lat_en` = 0. Next state is OPEN.
- OPEN: `lat_en` = one-hot of the captured address, `lat_d` held. Next state is HOLD.
- HOLD:
  - `lat_en` = 0, `lat_d` held. `wr_cnt` increments on entry to HOLD, saturating at 255.
  - Next state is SETUP on a valid transfer in HOLD (back-to-back), otherwise IDLE.
  - An invalid-address transfer in HOLD pulses `err_addr` and returns to IDLE.
- `lat_d` changes only on the SETUP entry edge. It keeps its last value in IDLE; it is not cleared.
- At most one `lat_en` bit is ever high. `lat_en` is never high in two consecutive cycles.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst_b` low, asynchronous): state = IDLE, `lat_d` = 0, `lat_en` = 0, `err_addr` = 0, `wr_cnt` = 0, `busy` = 0, `wr_rdy` = 1.
  - Outputs drop immediately on assertion, including mid-write; an interrupted write is lost and not counted.
  - Reset release is synchronous to `clk` (the external synchronizer is assumed in the integration).
- Latency from the transfer edge (cycle 0):
  - `lat_d` valid in cycle 1 (SETUP).
  - `lat_en` high for exactly cycle 2 (OPEN).
  - `lat_d` stable through cycle 3 (HOLD).
  - `wr_cnt` updates at the end of cycle 2, visible in cycle 3.
- Throughput: back-to-back writes complete one per 3 cycles. Successive `lat_en` pulses are 3 cycles apart.
- `err_addr` is high exactly one cycle after the offending transfer.
- Setup guarantee: ≥1 full cycle of stable `lat_d` before `lat_en` rises.
- Hold guarantee: ≥1 full cycle of stable `lat_d` after `lat_en` falls.

## Test plan
- Reset mid-operation:
  - Stimulus: reset, then write addr 3 / data 0xA5A5; assert `rst_b` low during OPEN.
  - Required: `lat_en` = 0 and `lat_d` = 0 immediately, `wr_cnt` = 0, `wr_rdy` = 1 after release.
- Single write:
  - Stimulus: write addr 5 / 0x1234.
  - Required: `lat_d` = 0x1234 in cycles 1–3; `lat_en` = 8'b0010_0000 only in cycle 2; `busy` high in cycles 1–3; `wr_cnt` = 1.
- Back-to-back:
  - Stimulus: hold `wr_vld` with addrs 0, 7, 2 and data 0x1111, 0x7777, 0x2222.
  - Required: `lat_en` pulses 0x01, 0x80, 0x04 at cycles 2, 5, 8; `lat_d` changes only at cycles 1, 4, 7; `wr_rdy` low in SETUP and OPEN; `wr_cnt` = 3.
- Bad address:
  - Stimulus: `DEPTH`=6, write addr 6 and then addr 7 from IDLE.
  - Required: `err_addr` pulses each time; `lat_en` stays 0; `wr_cnt` unchanged; a following addr-4 write works normally.
- Bad address during HOLD:
  - Stimulus: request addr 6 (with `DEPTH`=6) during HOLD of a good write.
  - Required: `err_addr` pulses; state returns to IDLE.
- Saturation:
  - Stimulus: 260 valid writes.
  - Required: `wr_cnt` = 255 and remains 255.
- Random-stall stress:
  - Stimulus: random `wr_vld` with a scoreboard model.
  - Required: `lat_en` is one-hot or zero every cycle, never high in adjacent cycles, and `lat_d` is stable from SETUP through HOLD.
